axis_master_packetizer: RTL and testbench

- Upstream AXI-Stream master stage. It feeds the AXI-Stream slave block on the tvalid/tready/tdata/tstrb/tkeep/tlast/TID/TDEST/TUSER channel.
- A local producer pushes data beats through a simple valid/ready interface into an internal FIFO. The block drains the FIFO onto the stream with full AXI handshake compliance.
- It generates tkeep/tstrb from a byte count, enforces a maximum packet length (MAX_BEATS), counts completed packets and flags forced truncations.

---
 rtl/axis_master_packetizer.sv | 122 ++++++++++++
 tb/tb_axis_master_packetizer.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/axis_master_packetizer.sv
// AXI-Stream master packetizer: buffers producer beats in a small FIFO and drains them
// onto the stream with keep/strobe generation, packet-length capping and packet counting.
module axis_master_packetizer #(
  parameter int N         = 4,
  parameter int DEPTH     = 8,
  parameter int MAX_BEATS = 32,
  parameter int ID_VAL    = 0,
  parameter int DEST_VAL  = 0
) (
  input  logic                       aclk,
  input  logic                       areset,
  input  logic                       src_valid,
  output logic                       src_ready,
  input  logic [8*N-1:0]             src_data,
  input  logic [$clog2(N):0]         src_nbytes,
  input  logic                       src_last,
  output logic                       tvalid,
  input  logic                       tready,
  output logic [8*N-1:0]             tdata,
  output logic [N-1:0]               tstrb,
  output logic [N-1:0]               tkeep,
  output logic                       tlast,
  output logic                       TID,
  output logic                       TDEST,
  output logic                       TUSER,
  output logic [$clog2(DEPTH):0]     fifo_count,
  output logic [15:0]                pkt_count,
  output logic                       trunc_pulse
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int BW = $clog2(MAX_BEATS + 1);

  logic [8*N-1:0] r_mem_data [DEPTH];
  logic [N-1:0]   r_mem_keep [DEPTH];
  logic           r_mem_last [DEPTH];

  logic [AW-1:0]  r_wr_ptr;
  logic [AW-1:0]  r_rd_ptr;
  logic [CW-1:0]  r_count;
  logic [BW-1:0]  r_beat_cnt;
  logic [15:0]    r_pkt_count;
  logic           r_trunc_pulse;

  logic           w_push;
  logic           w_pop;
  logic           w_force;
  logic [N-1:0]   w_keep;
  logic [8*N-1:0] w_data;

  // NOTE: every variable written in always_comb gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    w_keep = '0;
    w_data = '0;
    for (int i = 0; i < N; i++) begin
      w_keep[i] = (src_nbytes == '0) || (int'(src_nbytes) > N) || (i < int'(src_nbytes));
      w_data[8*i +: 8] = w_keep[i] ? src_data[8*i +: 8] : 8'h00;
    end
  end

  assign src_ready = !areset && (r_count < CW'(DEPTH));
  assign tvalid    = (r_count != '0);
  assign w_push    = src_valid && src_ready;
  assign w_pop     = tvalid && tready;

  // Head beat is cut short when the packet has already used MAX_BEATS-1 beats.
  assign w_force = !r_mem_last[r_rd_ptr] && (r_beat_cnt == BW'(MAX_BEATS - 1));

  assign tdata       = tvalid ? r_mem_data[r_rd_ptr] : '0;
  assign tkeep       = tvalid ? r_mem_keep[r_rd_ptr] : '0;
  assign tstrb       = tkeep;
  assign tlast       = tvalid && (r_mem_last[r_rd_ptr] || w_force);
  assign TUSER       = tvalid && w_force;
  assign TID         = 1'(ID_VAL);
  assign TDEST       = 1'(DEST_VAL);
  assign fifo_count  = r_count;
  assign pkt_count   = r_pkt_count;
  assign trunc_pulse = r_trunc_pulse;

  // NOTE: the storage array has no reset; validity comes from r_count, so clearing it
  // would only add reset fan-out to every bit.
  always_ff @(posedge aclk) begin
    if (w_push) begin
      r_mem_data[r_wr_ptr] <= w_data;
      r_mem_keep[r_wr_ptr] <= w_keep;
      r_mem_last[r_wr_ptr] <= src_last;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge aclk) begin
    if (areset) begin
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_count       <= '0;
      r_beat_cnt    <= '0;
      r_pkt_count   <= '0;
      r_trunc_pulse <= 1'b0;
    end else begin
      r_trunc_pulse <= w_pop && w_force;
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
        if (tlast) begin
          r_beat_cnt  <= '0;
          r_pkt_count <= r_pkt_count + 16'd1;
        end else begin
          r_beat_cnt  <= r_beat_cnt + 1'b1;
        end
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: tb/tb_axis_master_packetizer.sv
// Scoreboard bench for axis_master_packetizer: a packet-position model predicts each output
// beat at accept time; a negedge monitor pops and compares every stream handshake.
module tb_axis_master_packetizer;

  localparam int N         = 4;
  localparam int DEPTH     = 8;
  localparam int MAX_BEATS = 32;

  typedef struct {
    logic [31:0] data;
    logic [3:0]  keep;
    logic        last;
    logic        user;
  } beat_t;

  logic        aclk = 1'b0;
  logic        areset = 1'b1;
  logic        src_valid = 1'b0;
  logic        src_ready;
  logic [31:0] src_data = '0;
  logic [2:0]  src_nbytes = '0;
  logic        src_last = 1'b0;
  logic        tvalid;
  logic        tready = 1'b0;
  logic [31:0] tdata;
  logic [3:0]  tstrb;
  logic [3:0]  tkeep;
  logic        tlast;
  logic        TID;
  logic        TDEST;
  logic        TUSER;
  logic [3:0]  fifo_count;
  logic [15:0] pkt_count;
  logic        trunc_pulse;

  axis_master_packetizer #(
    .N(N), .DEPTH(DEPTH), .MAX_BEATS(MAX_BEATS), .ID_VAL(0), .DEST_VAL(0)
  ) dut (
    .aclk(aclk), .areset(areset),
    .src_valid(src_valid), .src_ready(src_ready), .src_data(src_data),
    .src_nbytes(src_nbytes), .src_last(src_last),
    .tvalid(tvalid), .tready(tready), .tdata(tdata), .tstrb(tstrb), .tkeep(tkeep),
    .tlast(tlast), .TID(TID), .TDEST(TDEST), .TUSER(TUSER),
    .fifo_count(fifo_count), .pkt_count(pkt_count), .trunc_pulse(trunc_pulse)
  );

  always #5 aclk = ~aclk;

  int    n_cmp = 0;
  int    n_fail = 0;
  beat_t expq[$];
  int    pos = 0;     // beats already accepted in the current packet
  int    mode = 1;    // tready policy: 0 low, 1 high, 2 random

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected stream beat for an accepted producer beat, from its position in the packet.
  function automatic beat_t model(input logic [31:0] d, input int nb, input logic last);
    beat_t e;
    int    nv;
    nv = (nb == 0 || nb > N) ? N : nb;
    e.keep = 4'((1 << nv) - 1);
    e.data = '0;
    for (int b = 0; b < nv; b++) e.data[8*b +: 8] = d[8*b +: 8];
    pos++;
    e.user = !last && (pos == MAX_BEATS);
    e.last = last || (pos == MAX_BEATS);
    if (e.last) pos = 0;
    return e;
  endfunction

  task automatic push_beat(input logic [31:0] d, input int nb, input logic last);
    bit done = 0;
    int waited = 0;
    src_valid  = 1'b1;
    src_data   = d;
    src_nbytes = 3'(nb);
    src_last   = last;
    while (!done) begin
      @(negedge aclk);
      if (src_ready) begin
        expq.push_back(model(d, nb, last));
        done = 1;
      end else if (++waited > 2000) begin
        check("push_timeout", 64'(waited), 64'd0);
        done = 1;
      end
    end
    @(posedge aclk); #1;
    src_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int cyc = 0;
    while (expq.size() != 0 && cyc < 3000) begin
      @(posedge aclk);
      cyc++;
    end
    check("drain_left", 64'(expq.size()), 64'd0);
    repeat (3) @(posedge aclk);
    #1;
  endtask

  // tready driver, applied after the main process has updated the policy.
  initial begin
    forever begin
      @(posedge aclk); #2;
      case (mode)
        0:       tready = 1'b0;
        1:       tready = 1'b1;
        default: tready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: checks registered status against the model, then pops on each handshake.
  initial begin
    int          mcount = 0;
    logic [15:0] exp_pkt = '0;
    logic        exp_trunc = 1'b0;
    logic        next_trunc;
    bit          armed = 0, just_reset = 0, prev_stall = 0;
    logic [31:0] prev_data;
    logic [3:0]  prev_keep;
    logic        prev_last, prev_user;
    beat_t       e;
    forever begin
      @(negedge aclk);
      if (areset) begin
        check("src_ready_in_reset", 64'(src_ready), 64'd0);
        expq.delete();
        mcount = 0; exp_pkt = '0; exp_trunc = 1'b0;
        prev_stall = 0; armed = 1; just_reset = 1;
      end else if (armed) begin
        check("fifo_count", 64'(fifo_count), 64'(mcount));
        check("tvalid", 64'(tvalid), 64'(mcount != 0));
        check("src_ready", 64'(src_ready), 64'(mcount < DEPTH));
        check("pkt_count", 64'(pkt_count), 64'(exp_pkt));
        check("trunc_pulse", 64'(trunc_pulse), 64'(exp_trunc));
        check("tid_tdest", 64'({TID, TDEST}), 64'd0);
        if (just_reset)
          check("outputs_after_reset", 64'({tdata, tkeep, tstrb, tlast, TUSER}), 64'd0);
        just_reset = 0;
        if (prev_stall)
          check("stall_hold", 64'({tvalid, tdata, tkeep, tlast, TUSER}),
                64'({1'b1, prev_data, prev_keep, prev_last, prev_user}));
        prev_stall = tvalid && !tready;
        prev_data = tdata; prev_keep = tkeep; prev_last = tlast; prev_user = TUSER;
        next_trunc = 1'b0;
        if (tvalid && tready) begin
          if (expq.size() == 0) begin
            check("unexpected_beat", 64'(tdata), 64'd0);
          end else begin
            e = expq.pop_front();
            check("tdata", 64'(tdata), 64'(e.data));
            check("tkeep", 64'(tkeep), 64'(e.keep));
            check("tstrb", 64'(tstrb), 64'(e.keep));
            check("tlast", 64'(tlast), 64'(e.last));
            check("tuser", 64'(TUSER), 64'(e.user));
            if (e.last) exp_pkt = exp_pkt + 16'd1;
            next_trunc = e.user;
          end
          mcount--;
        end
        if (src_valid && src_ready) mcount++;
        exp_trunc = next_trunc;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (2) @(posedge aclk);
    #1 areset = 1'b0;

    // Basic 4-beat packet with continuous ready.
    mode = 1;
    for (int i = 1; i <= 4; i++) push_beat(32'(i), 4, i == 4);
    wait_drain();

    // Backpressure: fill all storage, then release.
    mode = 0;
    fork
      for (int i = 1; i <= 12; i++) push_beat(32'(i), 4, i == 12);
      begin repeat (20) @(posedge aclk); #1; mode = 1; end
    join
    wait_drain();

    // Partial and zero byte counts.
    push_beat(32'h11223344, 0, 1'b0);
    push_beat(32'h55667788, 3, 1'b0);
    push_beat(32'hAABBCCDD, 2, 1'b1);
    wait_drain();

    // Truncation at MAX_BEATS.
    for (int i = 1; i <= 40; i++) push_beat(32'(i), 4, i == 40);
    wait_drain();

    // Random ready and random beats.
    mode = 2;
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 3) == 0) begin @(posedge aclk); #1; end
      push_beat($urandom, int'($urandom_range(0, 7)), ($urandom_range(0, 7) == 0) || i == 199);
    end
    mode = 1;
    wait_drain();

    // Reset in mid-packet with beat 3 on the bus and 5 more queued.
    mode = 0;
    for (int i = 1; i <= 8; i++) push_beat(32'(100 + i), 4, 1'b0);
    mode = 1;
    repeat (2) @(posedge aclk);
    #1;
    mode = 0;
    areset = 1'b1;
    pos = 0;
    @(posedge aclk); #1;
    areset = 1'b0;
    mode = 1;
    push_beat(32'hC001, 4, 1'b0);
    push_beat(32'hC002, 4, 1'b1);
    wait_drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
